fifo_read_ctrl: RTL and testbench

//  Read-side pointer/flag controller of the async FIFO, mirror of the write-side controller.
//  - Synchronizes the write-domain Gray pointer into rclk.
//  - Maintains the binary/Gray read pointers and drives the read address into the FIFO memory.
//  - Generates the empty and fill-count flags, plus sticky underflow detection.
//  - Exports the Gray read pointer back to the write side for full detection.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_ptr_sync.sv | 31 +++
 rtl/fifo_read_ctrl.sv | 78 +++++++
 tb/tb_fifo_read_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and address width.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int GW = 32;

  typedef logic [GW-1:0] gword_t;

  function automatic int fifo_aw(int depth);
    return $clog2(depth);
  endfunction

  // Callers zero-extend to GW and size-cast the result back to AW+1.
  function automatic gword_t b2g(gword_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gword_t g2b(gword_t g);
    gword_t b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing clock domains.
// Synchronous active-high reset clears every stage to zero.
module fifo_ptr_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  // Shift the raw pointer through the chain; no logic before stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side pointer/flag controller (mirror of write side).
// Optional rd_almost_empty output: define FIFO_RD_ALMOST_EMPTY_EN.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2,
  localparam int AW         = fifo_aw(DEPTH)
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          rden,
  input  logic [AW:0]   wrptr,
  output logic [AW:0]   rdptr,
  output logic [AW-1:0] raddr,
  output logic          rd_fire,
  output logic          rd_empty,
  output logic [AW:0]   rd_count,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  output logic          rd_almost_empty,
`endif
  output logic          rd_underflow
);

  typedef logic [AW:0] ptr_t;

  ptr_t rbin;
  ptr_t rbin_next;
  ptr_t g_next;
  ptr_t q_wptr;
  ptr_t cnt_next;

  fifo_ptr_sync #(
    .W      (AW + 1),
    .STAGES (SYNC_STAGES)
  ) u_wsync (
    .clk (rclk),
    .rst (rrst),
    .d   (wrptr),
    .q   (q_wptr)
  );

  assign rd_fire   = rden & ~rd_empty;
  assign rbin_next = rbin + ptr_t'(rd_fire);
  assign g_next    = ptr_t'(b2g(gword_t'(rbin_next)));
  assign cnt_next  = ptr_t'(g2b(gword_t'(q_wptr))) - rbin_next;
  assign raddr     = rbin[AW-1:0];

  // Pointers and flags; pop and synced write fold into one update.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin         <= '0;
      rdptr        <= '0;
      rd_empty     <= 1'b1;
      rd_count     <= '0;
      rd_underflow <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rdptr        <= g_next;
      rd_empty     <= (g_next == q_wptr);
      rd_count     <= cnt_next;
      rd_underflow <= rd_underflow | (rden & rd_empty);
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  // Almost-empty tracks the next-state fill count.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_almost_empty <= 1'b1;
    end else begin
      rd_almost_empty <= (cnt_next <= ptr_t'(AE_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl (DEPTH=16, SYNC_STAGES=2).
// Writes push expected read addresses; a monitor pops on rd_fire.
module tb_fifo_read_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          rden = 1'b0;
  logic [AW:0]   wrptr = '0;
  logic [AW:0]   rdptr;
  logic [AW-1:0] raddr;
  logic          rd_fire;
  logic          rd_empty;
  logic [AW:0]   rd_count;
  logic          rd_underflow;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          rd_almost_empty;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int sb[$];

  fifo_read_ctrl #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2),
    .AE_THRESH   (2)
  ) dut (
    .rclk            (rclk),
    .rrst            (rrst),
    .rden            (rden),
    .wrptr           (wrptr),
    .rdptr           (rdptr),
    .raddr           (raddr),
    .rd_fire         (rd_fire),
    .rd_empty        (rd_empty),
    .rd_count        (rd_count),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    .rd_almost_empty (rd_almost_empty),
`endif
    .rd_underflow    (rd_underflow)
  );

  always #5 rclk = ~rclk;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  function automatic logic [AW:0] gray(int b);
    logic [AW:0] v;
    v = (AW + 1)'(b);
    return v ^ (v >> 1);
  endfunction

  // Monitor: every pop must match the oldest written address.
  always @(negedge rclk) begin
    if (rd_fire) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_fire: got raddr %0d expected no pop", raddr);
      end else begin
        chk("raddr", int'(raddr), sb.pop_front());
      end
    end
  end

  initial begin
    int wb;
    int seen_wrap;
    logic [AW:0] prev;

    // 1. reset
    rrst = 1'b1;
    tick(2);
    chk("rst_empty", rd_empty, 1);
    chk("rst_rdptr", rdptr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_uflow", rd_underflow, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("rst_ae", rd_almost_empty, 1);
`endif
    rrst = 1'b0;

    // 2. two entries arrive, then two reads
    wrptr = 5'b00011;
    sb.push_back(0);
    sb.push_back(1);
    tick(2);
    chk("lat_still_empty", rd_empty, 1);
    tick(1);
    chk("t2_empty", rd_empty, 0);
    chk("t2_count", rd_count, 2);
    rden = 1'b1;
    tick(2);
    rden = 1'b0;
    chk("t2_empty_after", rd_empty, 1);
    chk("t2_count_after", rd_count, 0);
    chk("t2_rdptr", rdptr, 5'b00011);

    // 3. underflow
    rden = 1'b1;
    tick(1);
    rden = 1'b0;
    chk("uflow_set", rd_underflow, 1);
    chk("uflow_rdptr", rdptr, 5'b00011);
    chk("uflow_raddr", raddr, 2);
    tick(2);
    chk("uflow_sticky", rd_underflow, 1);

    // 4. stream 40 writes with continuous reads across the wrap
    wb = 2;
    seen_wrap = 0;
    prev = rdptr;
    rden = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sb.push_back(wb % DEPTH);
      wb++;
      wrptr = gray(wb);
      tick(1);
      if (prev == 5'b10000 && rdptr == 5'b00000) seen_wrap = 1;
      prev = rdptr;
      chk("no_false_nonempty", int'(rd_empty || sb.size() > 0), 1);
    end
    for (int n = 0; n < 30 && !rd_empty; n++) begin
      tick(1);
      if (prev == 5'b10000 && rdptr == 5'b00000) seen_wrap = 1;
      prev = rdptr;
    end
    rden = 1'b0;
    chk("drain_empty", rd_empty, 1);
    chk("drain_count", rd_count, 0);
    chk("drain_rdptr", rdptr, 5'b01111);
    chk("drain_raddr", raddr, 10);
    chk("gray_wrap_seen", seen_wrap, 1);
    chk("sb_drained", sb.size(), 0);

    // reset clears sticky underflow
    rrst = 1'b1;
    wrptr = '0;
    tick(2);
    rrst = 1'b0;
    sb.delete();
    chk("uflow_cleared", rd_underflow, 0);
    chk("rst2_count", rd_count, 0);

    // 5. full FIFO seen from the read side
    wrptr = 5'b11000;
    for (int i = 0; i < DEPTH; i++) sb.push_back(i);
    tick(3);
    chk("full_count", rd_count, 16);
    chk("full_empty", rd_empty, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    chk("full_ae", rd_almost_empty, 0);
`endif
    rden = 1'b1;
    tick(11);
    chk("pop11_count", rd_count, 5);
    chk("pop11_rdptr", rdptr, 5'b01110);
    chk("pop11_raddr", raddr, 11);

    // 6. reset mid-stream with a read in flight
    rrst = 1'b1;
    wrptr = '0;
    tick(1);
    rden = 1'b0;
    chk("mid_rst_empty", rd_empty, 1);
    chk("mid_rst_count", rd_count, 0);
    chk("mid_rst_rdptr", rdptr, 0);
    chk("mid_rst_raddr", raddr, 0);
    tick(1);
    rrst = 1'b0;
    sb.delete();

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    // almost-empty threshold crossing
    wrptr = 5'b11000;
    for (int i = 0; i < DEPTH; i++) sb.push_back(i);
    tick(3);
    chk("ae_full", rd_almost_empty, 0);
    rden = 1'b1;
    tick(13);
    rden = 1'b0;
    chk("ae_cnt3", rd_count, 3);
    chk("ae_at3", rd_almost_empty, 0);
    rden = 1'b1;
    tick(1);
    rden = 1'b0;
    chk("ae_cnt2", rd_count, 2);
    chk("ae_at2", rd_almost_empty, 1);
    tick(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
